// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - constants and types shared by the serial link transmitter and receiver
package serial_link_pkg;

    localparam int SERIAL_WIDTH = 8;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - serial-in shift register, bit counter and word completion strobe
module sipo_shift_core
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = SERIAL_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sen,
    output logic [WIDTH-1:0] word,
    output logic             done,
    output logic             abort,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shreg_next;

    // Completed word is the shifted value including the bit sampled on this edge.
    assign shreg_next = MSB_FIRST ? {shreg_q[WIDTH-2:0], sin} : {sin, shreg_q[WIDTH-1:1]};
    assign word       = shreg_next;
    assign busy       = (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (sen) begin
                    shreg_d = shreg_next;
                    cnt_d   = CW'(1);
                    state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (sen) begin
                    shreg_d = shreg_next;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = RX_IDLE;
                        done    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    abort   = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/serial_rx_8b.sv
// rtl/serial_rx_8b.sv - serial-to-parallel receiver with one-entry valid/ready holding register
module serial_rx_8b
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = SERIAL_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sen,
    input  logic             dready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
);

    logic [WIDTH-1:0] word;
    logic             done;
    logic             abort;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             consume;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .sin   (sin),
        .sen   (sen),
        .word  (word),
        .done  (done),
        .abort (abort),
        .busy  (busy)
    );

    assign consume = dvalid_q & dready;

    always_comb begin
        dout_d      = dout_q;
        dvalid_d    = dvalid_q;
        overrun_d   = overrun_q;
        frame_err_d = abort;
        if (done && (!dvalid_q || consume)) begin
            dout_d   = word;
            dvalid_d = 1'b1;
        end else if (consume) begin
            dvalid_d = 1'b0;
        end
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        // A fresh drop on the same edge as a clear leaves the flag set.
        if (done && dvalid_q && !dready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign dout      = dout_q;
    assign dvalid    = dvalid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_rx_8b.sv
// tb/tb_serial_rx_8b.sv - directed self-checking bench for serial_rx_8b
module tb_serial_rx_8b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sin;
    logic       sen;
    logic       dready;
    logic       ovr_clr;
    logic [7:0] dout;
    logic       dvalid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    serial_rx_8b #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sen       (sen),
        .dready    (dready),
        .ovr_clr   (ovr_clr),
        .dout      (dout),
        .dvalid    (dvalid),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        sen = 1'b1;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic idle_edge();
        sen = 1'b0;
        sin = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] v;
        rst_n   = 1'b0;
        sin     = 1'b0;
        sen     = 1'b0;
        dready  = 1'b0;
        ovr_clr = 1'b0;
        #2;
        check("rst_dout", dout, 8'h00);
        check("rst_dvalid", dvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1: 0,1,1,0,0,1,0,1 MSB first = 8'h65
        send_bit(1'b0);
        check("t1_busy_mid", busy, 1'b1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("t1_dvalid_before", dvalid, 1'b0);
        send_bit(1'b1);
        check("t1_dout", dout, 8'h65);
        check("t1_dvalid", dvalid, 1'b1);
        check("t1_busy", busy, 1'b0);
        check("t1_overrun", overrun, 1'b0);
        idle_edge();
        check("t1_dout_hold", dout, 8'h65);

        // 2: back-to-back A5 then 3C with dready=1
        dready = 1'b1;
        idle_edge();
        check("t2_drain", dvalid, 1'b0);
        v = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        check("t2_dvalid_early", dvalid, 1'b0);
        send_bit(v[0]);
        check("t2_dvalid_a5", dvalid, 1'b1);
        check("t2_dout_a5", dout, 8'hA5);
        v = 8'h3C;
        send_bit(v[7]);
        check("t2_consumed", dvalid, 1'b0);
        check("t2_no_gap_busy", busy, 1'b1);
        for (int i = 6; i >= 0; i--) send_bit(v[i]);
        check("t2_dvalid_3c", dvalid, 1'b1);
        check("t2_dout_3c", dout, 8'h3C);
        check("t2_overrun", overrun, 1'b0);
        idle_edge();
        check("t2_drain2", dvalid, 1'b0);

        // 3: overrun
        dready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        check("t3_dout_kept", dout, 8'h11);
        check("t3_dvalid", dvalid, 1'b1);
        check("t3_overrun", overrun, 1'b1);
        dready = 1'b1;
        idle_edge();
        check("t3_consume", dvalid, 1'b0);
        check("t3_overrun_sticky", overrun, 1'b1);
        dready  = 1'b0;
        ovr_clr = 1'b1;
        idle_edge();
        ovr_clr = 1'b0;
        check("t3_ovr_clr", overrun, 1'b0);

        // 4: abort after 3 bits
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("t4_busy", busy, 1'b1);
        check("t4_no_err_yet", frame_err, 1'b0);
        idle_edge();
        check("t4_frame_err", frame_err, 1'b1);
        check("t4_busy_clear", busy, 1'b0);
        idle_edge();
        check("t4_frame_err_pulse", frame_err, 1'b0);
        send_byte(8'hF0);
        check("t4_dout_f0", dout, 8'hF0);
        check("t4_dvalid", dvalid, 1'b1);
        check("t4_frame_err_none", frame_err, 1'b0);
        idle_edge();

        // 5: completion on the consume edge
        v = 8'h96;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        check("t5_dout_held", dout, 8'hF0);
        dready = 1'b1;
        send_bit(v[0]);
        check("t5_dvalid", dvalid, 1'b1);
        check("t5_dout_96", dout, 8'h96);
        check("t5_overrun", overrun, 1'b0);
        dready = 1'b0;

        // 6: asynchronous reset mid-frame with dvalid=1
        v = 8'hC3;
        for (int i = 7; i >= 3; i--) send_bit(v[i]);
        check("t6_pre_busy", busy, 1'b1);
        check("t6_pre_dvalid", dvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_dout", dout, 8'h00);
        check("t6_rst_dvalid", dvalid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_overrun", overrun, 1'b0);
        check("t6_rst_frame_err", frame_err, 1'b0);
        sen = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send_byte(8'h5A);
        check("t6_dout_5a", dout, 8'h5A);
        check("t6_dvalid", dvalid, 1'b1);
        check("t6_frame_err", frame_err, 1'b0);
        idle_edge();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
